// File: rtl/tv80_reg_dump_pkg.sv
// Shared definitions for the TV80 register-file dump engine.
package tv80_reg_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SEND_A  = 3'd2,
        ST_SEND_B  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/tv80_reg_dump.sv
// Stalls the core and streams every register pair, one byte per transfer,
// over a valid/ready interface using the register file's third read port.
module tv80_reg_dump
    import tv80_reg_dump_pkg::*;
#(
    parameter int unsigned NUM_PAIRS  = 8,
    parameter int unsigned ADDR_W     = 3,
    parameter bit          HIGH_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [7:0]        reg_doh,
    input  logic [7:0]        reg_dol,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last
);

    localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NUM_PAIRS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        sh_h_q, sh_h_d;
    logic [7:0]        sh_l_q, sh_l_d;
    logic              is_last;
    logic              xfer;

    assign is_last = (cnt_q == LAST_PAIR);
    assign xfer    = tx_ready && ((state_q == ST_SEND_A) || (state_q == ST_SEND_B));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_h_q  <= '0;
            sh_l_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_h_q  <= sh_h_d;
            sh_l_q  <= sh_l_d;
        end
    end

    // abort overrides everything, including a transfer in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_h_d  = sh_h_q;
        sh_l_d  = sh_l_q;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_CAPTURE;
                        cnt_d   = '0;
                    end
                end
                ST_CAPTURE: begin
                    sh_h_d  = reg_doh;
                    sh_l_d  = reg_dol;
                    state_d = ST_SEND_A;
                end
                ST_SEND_A: begin
                    if (xfer) state_d = ST_SEND_B;
                end
                ST_SEND_B: begin
                    if (xfer) begin
                        if (is_last) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = ST_CAPTURE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        reg_addr = '0;
        tx_data  = '0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_CAPTURE: begin
                busy     = 1'b1;
                reg_addr = cnt_q;
            end
            ST_SEND_A: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = HIGH_FIRST ? sh_h_q : sh_l_q;
            end
            ST_SEND_B: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = HIGH_FIRST ? sh_l_q : sh_h_q;
                tx_last  = is_last;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign cpu_hold = busy;

endmodule

// File: tb/tb_tv80_reg_dump.sv
// Directed bench for tv80_reg_dump: byte stream checked through a scoreboard,
// control outputs checked cycle by cycle against the expected schedule.
module tb_tv80_reg_dump;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n, start, start_lf, abort, tx_ready;
    logic       busy, done, cpu_hold, tx_valid, tx_last;
    logic [2:0] reg_addr;
    logic [7:0] reg_doh, reg_dol, tx_data;
    logic       busy_lf, done_lf, cpu_hold_lf, tx_valid_lf, tx_last_lf;
    logic [2:0] reg_addr_lf;
    logic [7:0] reg_doh_lf, reg_dol_lf, tx_data_lf;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t q_hf[$];
    exp_t q_lf[$];

    always #5 clk = ~clk;

    function automatic logic [15:0] rf_val(input logic [2:0] a);
        case (a)
            3'd0:    return 16'h1234;
            3'd1:    return 16'h5678;
            3'd2:    return 16'h9ABC;
            default: return 16'h0000;
        endcase
    endfunction

    assign reg_doh    = rf_val(reg_addr)[15:8];
    assign reg_dol    = rf_val(reg_addr)[7:0];
    assign reg_doh_lf = rf_val(reg_addr_lf)[15:8];
    assign reg_dol_lf = rf_val(reg_addr_lf)[7:0];

    tv80_reg_dump #(.NUM_PAIRS(8), .ADDR_W(3), .HIGH_FIRST(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .cpu_hold(cpu_hold), .reg_addr(reg_addr),
        .reg_doh(reg_doh), .reg_dol(reg_dol), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last)
    );

    tv80_reg_dump #(.NUM_PAIRS(8), .ADDR_W(3), .HIGH_FIRST(1'b0)) dut_lf (
        .clk(clk), .reset_n(reset_n), .start(start_lf), .abort(abort),
        .busy(busy_lf), .done(done_lf), .cpu_hold(cpu_hold_lf), .reg_addr(reg_addr_lf),
        .reg_doh(reg_doh_lf), .reg_dol(reg_dol_lf), .tx_data(tx_data_lf),
        .tx_valid(tx_valid_lf), .tx_ready(tx_ready), .tx_last(tx_last_lf)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // byte i of a full dump; the first byte of a pair is H when hf=1
    function automatic logic [7:0] exp_byte(input int i, input bit hf);
        logic [15:0] v;
        v = rf_val(3'(i / 2));
        return (((i % 2) == 0) == hf) ? v[15:8] : v[7:0];
    endfunction

    task automatic push(input bit hf, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = exp_byte(i, hf);
            e.last = (i == 15);
            if (hf) q_hf.push_back(e);
            else    q_lf.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && !abort && tx_valid && tx_ready) begin
            exp_t e;
            chk("hf_byte_expected", {15'd0, q_hf.size() != 0}, 16'd1);
            if (q_hf.size() != 0) begin
                e = q_hf.pop_front();
                chk("hf_tx_data", {8'd0, tx_data}, {8'd0, e.data});
                chk("hf_tx_last", {15'd0, tx_last}, {15'd0, e.last});
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && !abort && tx_valid_lf && tx_ready) begin
            exp_t e;
            chk("lf_byte_expected", {15'd0, q_lf.size() != 0}, 16'd1);
            if (q_lf.size() != 0) begin
                e = q_lf.pop_front();
                chk("lf_tx_data", {8'd0, tx_data_lf}, {8'd0, e.data});
                chk("lf_tx_last", {15'd0, tx_last_lf}, {15'd0, e.last});
            end
        end
    end

    // cut_at > 0 ends the dump early in that cycle: abort if cut_abort, else reset
    task automatic dump(input bit lf, input int stall_from, input int stall_len,
                        input int again_at, input int cut_at, input bit cut_abort);
        int          done_at;
        logic        o_busy, o_hold, o_done, o_valid, o_last;
        logic [7:0]  o_data;
        logic [2:0]  o_addr;
        logic [15:0] outs;
        done_at = 25 + stall_len;
        if (lf) start_lf = 1'b1;
        else    start    = 1'b1;
        for (int k = 1; k <= done_at + 3; k++) begin
            tick();
            start    = 1'b0;
            start_lf = 1'b0;
            abort    = 1'b0;
            reset_n  = 1'b1;
            if (k == again_at) start = 1'b1;
            if (stall_len > 0 && k == stall_from) tx_ready = 1'b0;
            if (stall_len > 0 && k == stall_from + stall_len) tx_ready = 1'b1;
            if (cut_at > 0 && k == cut_at) begin
                if (cut_abort) abort = 1'b1;
                else           reset_n = 1'b0;
            end
            o_busy  = lf ? busy_lf     : busy;
            o_hold  = lf ? cpu_hold_lf : cpu_hold;
            o_done  = lf ? done_lf     : done;
            o_valid = lf ? tx_valid_lf : tx_valid;
            o_last  = lf ? tx_last_lf  : tx_last;
            o_data  = lf ? tx_data_lf  : tx_data;
            o_addr  = lf ? reg_addr_lf : reg_addr;
            outs    = {o_addr, o_data, o_valid, o_last, o_busy, o_done, o_hold};
            if (cut_at > 0 && k > cut_at) begin
                chk("cut_busy", {15'd0, o_busy}, 16'd0);
                chk("cut_done", {15'd0, o_done}, 16'd0);
                chk("cut_tx_valid", {15'd0, o_valid}, 16'd0);
                if (k == cut_at + 1 && !cut_abort) chk("reset_outputs_zero", outs, 16'd0);
            end else begin
                chk("busy", {15'd0, o_busy}, {15'd0, k < done_at});
                chk("cpu_hold", {15'd0, o_hold}, {15'd0, k < done_at});
                chk("done", {15'd0, o_done}, {15'd0, k == done_at});
                if (stall_len == 0 && k < done_at && ((k - 1) % 3) == 0)
                    chk("reg_addr", {13'd0, o_addr}, 16'((k - 1) / 3));
                if (stall_len > 0 && k >= stall_from && k < stall_from + stall_len) begin
                    chk("stall_tx_valid", {15'd0, o_valid}, 16'd1);
                    chk("stall_tx_data", {8'd0, o_data}, 16'h0056);
                end
            end
        end
        chk("queue_drained", 16'(lf ? q_lf.size() : q_hf.size()), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired compared=%0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        start_lf = 1'b0;
        abort    = 1'b0;
        tx_ready = 1'b1;
        tick();
        tick();
        chk("reset_state_hf", {reg_addr, tx_data, tx_valid, tx_last, busy, done, cpu_hold}, 16'd0);
        chk("reset_state_lf", {reg_addr_lf, tx_data_lf, tx_valid_lf, tx_last_lf,
                               busy_lf, done_lf, cpu_hold_lf}, 16'd0);
        reset_n = 1'b1;
        tick();

        push(1'b1, 16);
        dump(1'b0, 0, 0, 0, 0, 1'b0);

        // 5-cycle stall on byte 3, plus a start pulse mid-dump that must be dropped
        push(1'b1, 16);
        dump(1'b0, 5, 5, 8, 0, 1'b0);

        push(1'b0, 16);
        dump(1'b1, 0, 0, 0, 0, 1'b0);

        // abort while byte 4 is on the bus: only three bytes count as sent
        push(1'b1, 3);
        dump(1'b0, 0, 0, 0, 6, 1'b1);

        push(1'b1, 16);
        dump(1'b0, 0, 0, 0, 0, 1'b0);

        // reset while byte 7 is on the bus: six bytes were sent
        push(1'b1, 6);
        dump(1'b0, 0, 0, 0, 11, 1'b0);

        start = 1'b1;
        abort = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            start = 1'b0;
            abort = 1'b0;
            chk("start_abort_idle_busy", {15'd0, busy}, 16'd0);
            chk("start_abort_idle_valid", {15'd0, tx_valid}, 16'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
